// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter: arbitration states,
// register-index width and the saturating wait-counter helper.
package wb_port_arbiter_pkg;

    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [0:0] {
        LSU_PRIO = 1'b0,
        EX_FORCE = 1'b1
    } arb_state_e;

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [WAIT_CNT_W-1:0] sat_inc(
        input logic [WAIT_CNT_W-1:0] cnt,
        input logic [WAIT_CNT_W-1:0] limit
    );
        if (cnt >= limit) begin
            return limit;
        end
        return cnt + WAIT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/wb_port_arbiter.sv
// Two-requester register-file write-back arbiter: LSU normally wins conflicts,
// execute gets a forced grant after waiting MAX_WAIT cycles.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,

    input  logic                 i_ex_valid,
    output logic                 o_ex_ready,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic [XLEN-1:0]      i_ex_wdata,

    input  logic                 i_lsu_valid,
    output logic                 o_lsu_ready,
    input  logic [REG_IDX_W-1:0] i_lsu_rd,
    input  logic [XLEN-1:0]      i_lsu_wdata,

    output logic                 o_rf_rd_we,
    output logic [REG_IDX_W-1:0] o_rf_rd_addr,
    output logic [XLEN-1:0]      o_rf_rd_wdata,

    output logic                 o_ex_starved
);

    localparam logic [WAIT_CNT_W-1:0] WaitLimit = WAIT_CNT_W'(MAX_WAIT);

    arb_state_e              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_q, wait_d;

    logic                    ex_ready, lsu_ready;
    logic                    ex_accept, lsu_accept;

    logic                    rf_we_d, rf_we_q;
    logic [REG_IDX_W-1:0]    rf_addr_d, rf_addr_q;
    logic [XLEN-1:0]         rf_wdata_d, rf_wdata_q;

    // Ready is a function of the other requester's valid and the state only.
    always_comb begin
        ex_ready   = i_rst_n & (~i_lsu_valid | (state_q == EX_FORCE));
        lsu_ready  = i_rst_n & (~i_ex_valid  | (state_q == LSU_PRIO));
        ex_accept  = i_ex_valid  & ex_ready;
        lsu_accept = i_lsu_valid & lsu_ready;
    end

    always_comb begin
        wait_d = '0;
        if (i_ex_valid && !ex_accept) begin
            wait_d = sat_inc(wait_q, WaitLimit);
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= LSU_PRIO;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LSU_PRIO: begin
                if (wait_d == WaitLimit) begin
                    state_d = EX_FORCE;
                end
            end
            EX_FORCE: begin
                if (ex_accept) begin
                    state_d = LSU_PRIO;
                end
            end
            default: state_d = LSU_PRIO;
        endcase
    end

    // Output logic
    always_comb begin
        o_ex_ready   = ex_ready;
        o_lsu_ready  = lsu_ready;
        o_ex_starved = (state_q == EX_FORCE);
    end

    // Writes to x0 are consumed but never reach the register file.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        if (ex_accept && (i_ex_rd != '0)) begin
            rf_we_d    = 1'b1;
            rf_addr_d  = i_ex_rd;
            rf_wdata_d = i_ex_wdata;
        end else if (lsu_accept && (i_lsu_rd != '0)) begin
            rf_we_d    = 1'b1;
            rf_addr_d  = i_lsu_rd;
            rf_wdata_d = i_lsu_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign o_rf_rd_we    = rf_we_q;
    assign o_rf_rd_addr  = rf_addr_q;
    assign o_rf_rd_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_wb_port_arbiter;

    localparam int unsigned XLEN = 32;
    localparam int          MW   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, lsu_valid = 1'b0;
    logic [4:0]  ex_rd = '0, lsu_rd = '0;
    logic [31:0] ex_wdata = '0, lsu_wdata = '0;
    logic        ex_ready, lsu_ready, rf_we, ex_starved;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_err = 0;

    // Behavioural model state
    bit          m_ex_prio = 0;
    int          m_wait = 0;
    logic        m_we = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.XLEN(XLEN), .MAX_WAIT(MW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ex_valid   (ex_valid),
        .o_ex_ready   (ex_ready),
        .i_ex_rd      (ex_rd),
        .i_ex_wdata   (ex_wdata),
        .i_lsu_valid  (lsu_valid),
        .o_lsu_ready  (lsu_ready),
        .i_lsu_rd     (lsu_rd),
        .i_lsu_wdata  (lsu_wdata),
        .o_rf_rd_we   (rf_we),
        .o_rf_rd_addr (rf_addr),
        .o_rf_rd_wdata(rf_wdata),
        .o_ex_starved (ex_starved)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ex_prio = 0;
        m_wait    = 0;
        m_we      = 0;
        m_addr    = '0;
        m_data    = '0;
    endtask

    // One clock cycle: drive, check readies, clock, advance model, check outputs.
    task automatic step(input logic ev, input logic [4:0] erd, input logic [31:0] ewd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                        output logic er, output logic lr);
        bit ex_acc, lsu_acc;
        @(negedge clk);
        ex_valid = ev;  ex_rd = erd;  ex_wdata = ewd;
        lsu_valid = lv; lsu_rd = lrd; lsu_wdata = lwd;
        #1;
        er = ex_ready;
        lr = lsu_ready;
        chk("ex_ready",  er, !lv || m_ex_prio);
        chk("lsu_ready", lr, !ev || !m_ex_prio);
        ex_acc  = ev && (!lv || m_ex_prio);
        lsu_acc = lv && !ex_acc;
        @(posedge clk);
        #1;
        if (ex_acc || !ev) m_wait = 0;
        else m_wait = (m_wait + 1 > MW) ? MW : m_wait + 1;
        if (m_ex_prio) begin
            if (ex_acc) m_ex_prio = 0;
        end else if (m_wait == MW) begin
            m_ex_prio = 1;
        end
        m_we = 0;
        if (ex_acc && erd != 0) begin
            m_we = 1; m_addr = erd; m_data = ewd;
        end else if (lsu_acc && lrd != 0) begin
            m_we = 1; m_addr = lrd; m_data = lwd;
        end
        chk("rf_we",      rf_we,      m_we);
        chk("rf_addr",    rf_addr,    m_addr);
        chk("rf_wdata",   rf_wdata,   m_data);
        chk("ex_starved", ex_starved, m_ex_prio);
    endtask

    logic er, lr;
    int   starve_exp [6] = '{0, 0, 0, 1, 0, 0};
    int   exrdy_exp  [6] = '{0, 0, 0, 0, 1, 0};

    initial begin
        // Reset state
        #2;
        chk("reset_we",      rf_we,      0);
        chk("reset_addr",    rf_addr,    0);
        chk("reset_wdata",   rf_wdata,   0);
        chk("reset_starved", ex_starved, 0);
        chk("reset_ex_rdy",  ex_ready,   0);
        chk("reset_lsu_rdy", lsu_ready,  0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 0, er, lr);
            chk("idle_we", rf_we, 0);
            chk("idle_starved", ex_starved, 0);
        end

        // Execute only
        step(1, 5, 32'h1234, 0, 0, 0, er, lr);
        chk("exonly_ready", er, 1);
        chk("exonly_we", rf_we, 1);
        chk("exonly_addr", rf_addr, 5);
        chk("exonly_wdata", rf_wdata, 32'h1234);

        // Conflict: LSU wins
        step(1, 3, 32'h3333, 1, 7, 32'hDEAD, er, lr);
        chk("conf_lsu_ready", lr, 1);
        chk("conf_ex_ready", er, 0);
        chk("conf_addr", rf_addr, 7);
        chk("conf_wdata", rf_wdata, 32'hDEAD);

        // Drain the held execute request
        step(1, 3, 32'h3333, 0, 0, 0, er, lr);
        chk("drain_addr", rf_addr, 3);

        // x0 write from LSU is consumed silently
        step(0, 0, 0, 1, 0, 32'hFFFF_FFFF, er, lr);
        chk("x0_ready", lr, 1);
        chk("x0_we", rf_we, 0);
        chk("x0_addr", rf_addr, 3);
        chk("x0_wdata", rf_wdata, 32'h3333);

        // Starvation: execute held, LSU held for 6 cycles
        for (int i = 0; i < 6; i++) begin
            step(i < 5, 2, 32'hABCD, 1, 9, 32'h100 + i, er, lr);
            chk("starve_ex_ready", er, exrdy_exp[i]);
            chk("starve_flag", ex_starved, starve_exp[i]);
        end
        chk("starve_grant_addr", rf_addr, 9);

        // Reset mid-operation discards accepted ex rd=9
        @(negedge clk);
        ex_valid = 1; ex_rd = 9; ex_wdata = 32'h9999;
        lsu_valid = 0;
        #1;
        chk("midrst_accept", ex_ready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", rf_we, 0);
        chk("midrst_addr", rf_addr, 0);
        chk("midrst_wdata", rf_wdata, 0);
        chk("midrst_ex_rdy", ex_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("midrst_no_write", rf_we, 0);
        chk("midrst_addr_hold", rf_addr, 0);
        @(negedge clk);
        ex_valid = 0;
        rst_n = 1'b1;

        // Randomized traffic honouring input stability while stalled
        begin
            logic       ev = 0, lv = 0;
            logic [4:0] erd = 0, lrd = 0;
            logic [31:0] ewd = 0, lwd = 0;
            for (int i = 0; i < 2000; i++) begin
                if (!(ev && !er)) begin
                    ev  = ($urandom_range(0, 9) < 6);
                    erd = 5'($urandom_range(0, 31));
                    ewd = $urandom;
                end
                if (!(lv && !lr)) begin
                    lv  = ($urandom_range(0, 9) < 6);
                    lrd = 5'($urandom_range(0, 31));
                    lwd = $urandom;
                end
                step(ev, erd, ewd, lv, lrd, lwd, er, lr);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
